// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Oversampling UART receiver with configurable data width, optional
//            parity, 1/2 stop bits, 3-sample majority voting and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    localparam logic [PRESCALE_W-1:0] c_PRE_MIN  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] c_ONE      = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] c_TWO      = PRESCALE_W'(2);
    localparam logic [BIT_W-1:0]      c_LAST_BIT = BIT_W'(DATA_W - 1);

    logic                  sync1_q, rxs_q;
    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  stop1_q, stop1_d;
    logic [DATA_W-1:0]     pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;
    logic                  sg_q, sg_d;

    logic [PRESCALE_W-1:0] w_pre_fix;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_edge_nxt;
    logic                  w_last;
    logic                  w_dec;
    logic                  w_bit;
    logic                  w_serr;

    // Odd or too-small ratios cannot centre three samples in a bit, so fall back to 8.
    assign w_pre_fix  = (prescale[0] || (prescale < c_PRE_MIN)) ? c_PRE_MIN : prescale;
    assign w_half     = pre_q >> 1;
    assign w_last     = (edge_q == (pre_q - c_ONE));
    assign w_dec      = (edge_q == (w_half + c_TWO));
    assign w_edge_nxt = w_last ? '0 : (edge_q + c_ONE);
    assign w_bit      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign w_serr     = serr_q | (w_dec & ~w_bit);

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        pre_d     = pre_q;
        perr_d    = perr_q;
        serr_d    = serr_q;
        stop1_d   = stop1_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        sg_d      = 1'b0;

        samp_d    = samp_q;
        if (edge_q == (w_half - c_ONE)) samp_d[0] = rxs_q;
        if (edge_q == w_half)           samp_d[1] = rxs_q;
        if (edge_q == (w_half + c_ONE)) samp_d[2] = rxs_q;

        case (state_q)
            c_IDLE: begin
                edge_d = '0;
                if (!rxs_q) begin
                    state_d   = c_START;
                    bit_d     = '0;
                    perr_d    = 1'b0;
                    serr_d    = 1'b0;
                    stop1_d   = 1'b0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                    pre_d     = w_pre_fix;
                end
            end
            c_START: begin
                edge_d = w_edge_nxt;
                if (w_dec && w_bit) begin
                    state_d = c_IDLE;
                    edge_d  = '0;
                    sg_d    = 1'b1;
                end else if (w_last) begin
                    state_d = c_DATA;
                end
            end
            c_DATA: begin
                edge_d = w_edge_nxt;
                if (w_dec) shift_d = {w_bit, shift_q[DATA_W-1:1]};
                if (w_last) begin
                    if (bit_q == c_LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_q ? c_PARITY : c_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            c_PARITY: begin
                edge_d = w_edge_nxt;
                if (w_dec)  perr_d  = (((^shift_q) ^ w_bit) != par_typ_q);
                if (w_last) state_d = c_STOP;
            end
            c_STOP: begin
                edge_d = w_edge_nxt;
                serr_d = w_serr;
                if (stop2_q && !stop1_q) begin
                    if (w_last) stop1_d = 1'b1;
                end else if (w_dec) begin
                    // Leave mid-bit so a start edge late in the stop bit is not missed.
                    state_d = c_DONE;
                    edge_d  = '0;
                    if (!perr_q && !w_serr) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end else begin
                        pe_d = perr_q;
                        se_d = w_serr;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                edge_d  = '0;
            end
            default: begin
                state_d = c_IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= c_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            pre_q     <= c_PRE_MIN;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            stop1_q   <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
            sg_q      <= 1'b0;
        end else begin
            sync1_q   <= RX_IN;
            rxs_q     <= sync1_q;
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            pre_q     <= pre_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            stop1_q   <= stop1_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
            sg_q      <= sg_d;
        end
    end

    assign P_DATA      = pdata_q;
    assign data_valid  = dv_q;
    assign par_err     = pe_q;
    assign stp_err     = se_q;
    assign strt_glitch = sg_q;
    assign busy        = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Directed frames against a frame-level line model of uart_rx_cfg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;
    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 6;

    logic                  CLK;
    logic                  RST;
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESCALE_W-1:0] prescale;
    logic [DATA_W-1:0]     P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_dv = 0, obs_pe = 0, obs_se = 0, obs_sg = 0;
    int base_dv = 0, base_pe = 0, base_se = 0, base_sg = 0;

    uart_rx_cfg #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .STOP2       (STOP2),
        .prescale    (prescale),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch),
        .busy        (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
        end
    endtask

    // Line model: rx_s is RX_IN two clocks late; a frame starts the cycle after rx_s is
    // seen low while idle, and each bit is decided by majority of its three centre samples.
    initial begin : model
        int   cyc, s, mode, p, rel, k, e, last;
        logic sy1, rxs, h1, h2, h3, b;
        logic m_pe, m_pt, m_st2, m_perr, m_serr;
        logic pdv, ppe, pse, psg;
        logic [DATA_W-1:0] m_data, m_pdata, pend_data;
        logic [DATA_W+4:0] got, want;
        cyc = 0; s = 0; mode = 0; p = 8; last = 0;
        sy1 = 1'b1; rxs = 1'b1; h1 = 1'b1; h2 = 1'b1; h3 = 1'b1; b = 1'b0;
        m_pe = 1'b0; m_pt = 1'b0; m_st2 = 1'b0; m_perr = 1'b0; m_serr = 1'b0;
        pdv = 1'b0; ppe = 1'b0; pse = 1'b0; psg = 1'b0;
        m_data = '0; m_pdata = '0; pend_data = '0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (RST) begin
                sy1 = 1'b1; rxs = 1'b1; h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
                mode = 0;
                pdv = 1'b0; ppe = 1'b0; pse = 1'b0; psg = 1'b0;
                m_pdata = '0;
                want = '0;
            end else begin
                h3 = h2; h2 = h1; h1 = rxs; rxs = sy1; sy1 = RX_IN;
                if (pdv) m_pdata = pend_data;
                want = {(mode != 0), pdv, ppe, pse, psg, m_pdata};
                pdv = 1'b0; ppe = 1'b0; pse = 1'b0; psg = 1'b0;
                if (mode == 2) begin
                    mode = 0;
                end else if (mode == 0) begin
                    if (!rxs) begin
                        mode = 1;
                        s    = cyc + 1;
                    end
                end else if (cyc == s) begin
                    p = int'(prescale);
                    if ((p % 2) != 0 || p < 8) p = 8;
                    m_pe = PAR_EN; m_pt = PAR_TYP; m_st2 = STOP2;
                    m_data = '0; m_perr = 1'b0; m_serr = 1'b0;
                    last = DATA_W + 1 + int'(m_pe) + int'(m_st2);
                end else begin
                    rel = cyc - s;
                    k   = rel / p;
                    e   = rel % p;
                    if (e == p / 2 + 2) begin
                        b = ((int'(h1) + int'(h2) + int'(h3)) >= 2);
                        if (k == 0) begin
                            if (b) begin
                                psg  = 1'b1;
                                mode = 0;
                            end
                        end else if (k <= DATA_W) begin
                            m_data[k-1] = b;
                        end else if (m_pe && k == DATA_W + 1) begin
                            m_perr = (((^m_data) ^ b) != m_pt);
                        end else begin
                            if (!b) m_serr = 1'b1;
                            if (k == last) begin
                                mode = 2;
                                if (!m_perr && !m_serr) begin
                                    pdv       = 1'b1;
                                    pend_data = m_data;
                                end else begin
                                    ppe = m_perr;
                                    pse = m_serr;
                                end
                            end
                        end
                    end
                end
            end
            got = {busy, data_valid, par_err, stp_err, strt_glitch, P_DATA};
            if (data_valid)  obs_dv++;
            if (par_err)     obs_pe++;
            if (stp_err)     obs_se++;
            if (strt_glitch) obs_sg++;
            check($sformatf("cycle%0d {busy,dv,pe,se,sg,data}", cyc), int'(got), int'(want));
        end
    end

    task automatic send_bits(input logic [15:0] bits, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            RX_IN = bits[i];
            repeat (per) @(negedge CLK);
        end
    endtask

    task automatic idle(input int c);
        RX_IN = 1'b1;
        repeat (c) @(negedge CLK);
    endtask

    task automatic snap();
        base_dv = obs_dv;
        base_pe = obs_pe;
        base_se = obs_se;
        base_sg = obs_sg;
    endtask

    initial begin : stim
        logic [15:0] fr;
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        prescale = 6'd8;
        repeat (3) @(negedge CLK);
        check("reset_pdata", int'(P_DATA), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pulses", int'({data_valid, par_err, stp_err, strt_glitch}), 0);
        RST = 1'b0;
        idle(10);

        // P=8, 8N1, 0xA5
        snap();
        send_bits({1'b1, 8'hA5, 1'b0}, 10, 8);
        idle(24);
        check("t1_dv_count", obs_dv - base_dv, 1);
        check("t1_err_count", (obs_pe - base_pe) + (obs_se - base_se) + (obs_sg - base_sg), 0);
        check("t1_pdata", int'(P_DATA), 'hA5);

        // P=16, even parity, 0x0F sent with wrong parity bit 1
        prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        idle(4);
        snap();
        send_bits({1'b1, 1'b1, 8'h0F, 1'b0}, 11, 16);
        idle(48);
        check("t2_pe_count", obs_pe - base_pe, 1);
        check("t2_dv_count", obs_dv - base_dv, 0);
        check("t2_pdata_kept", int'(P_DATA), 'hA5);

        // P=16, start glitch 3 clocks low, then a good frame
        PAR_EN = 1'b0;
        idle(4);
        snap();
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        idle(48);
        check("t3_sg_count", obs_sg - base_sg, 1);
        check("t3_busy_idle", int'(busy), 0);
        snap();
        send_bits({1'b1, 8'hC3, 1'b0}, 10, 16);
        idle(48);
        check("t3_dv_count", obs_dv - base_dv, 1);
        check("t3_pdata", int'(P_DATA), 'hC3);

        // P=8, two stop bits: second stop low, then both high
        prescale = 6'd8; STOP2 = 1'b1;
        idle(4);
        snap();
        send_bits({1'b0, 1'b1, 8'h96, 1'b0}, 11, 8);
        idle(40);
        check("t4_se_count", obs_se - base_se, 1);
        check("t4_dv_pe_count", (obs_dv - base_dv) + (obs_pe - base_pe), 0);
        check("t4_pdata_kept", int'(P_DATA), 'hC3);
        snap();
        send_bits({2'b11, 8'h69, 1'b0}, 11, 8);
        idle(40);
        check("t4_dv_count", obs_dv - base_dv, 1);
        check("t4_pdata", int'(P_DATA), 'h69);

        // P=32, 0x3C with a 1-clock inversion on the centre sample of data bit 2
        prescale = 6'd32; STOP2 = 1'b0;
        idle(4);
        snap();
        fr = {6'b0, 1'b1, 8'h3C, 1'b0};
        send_bits(fr, 3, 32);
        RX_IN = 1'b1;
        repeat (17) @(negedge CLK);
        RX_IN = 1'b0;
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (14) @(negedge CLK);
        send_bits(fr >> 4, 6, 32);
        idle(100);
        check("t5_dv_count", obs_dv - base_dv, 1);
        check("t5_pdata", int'(P_DATA), 'h3C);

        // P=8 back-to-back 0x55, 0xAA, then reset in the middle of a third frame
        prescale = 6'd8;
        idle(4);
        snap();
        send_bits({1'b1, 8'h55, 1'b0}, 10, 8);
        send_bits({1'b1, 8'hAA, 1'b0}, 10, 8);
        send_bits(16'h000A, 4, 8);
        check("t6_dv_count", obs_dv - base_dv, 2);
        check("t6_pdata_aa", int'(P_DATA), 'hAA);
        snap();
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(negedge CLK);
        check("t6_rst_pdata", int'(P_DATA), 0);
        check("t6_rst_busy", int'(busy), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        idle(30);
        check("t6_no_pulse", (obs_dv - base_dv) + (obs_pe - base_pe) + (obs_se - base_se) + (obs_sg - base_sg), 0);
        snap();
        send_bits({1'b1, 8'h5A, 1'b0}, 10, 8);
        idle(24);
        check("t6_after_rst_dv", obs_dv - base_dv, 1);
        check("t6_after_rst_pdata", int'(P_DATA), 'h5A);

        idle(4);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
